// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - HI/LO issue controller for the multiply/divide unit (optional MD_FORWARD_EN)
module md_issue_ctrl #(
  parameter int DIVZ_SKIP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  output logic        req_ready,
  input  logic        flush,
  input  logic        rd_en,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic [31:0] md_src0,
  output logic [31:0] md_src1,
  output logic [1:0]  md_op,
  output logic        md_sign,
  output logic        md_in_valid,
  input  logic        md_in_ready,
  input  logic        md_out_valid,
  output logic        md_out_ready,
  input  logic [31:0] md_res0,
  input  logic [31:0] md_res1
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] src0_q, src0_d;
  logic [31:0] src1_q, src1_d;
  logic [1:0]  op_q, op_d;
  logic        sign_q, sign_d;

  logic accept;
  logic is_div;
  logic div_skip;
  logic hazard_req;
  logic fwd;

  assign accept   = req_valid & (state_q == S_IDLE) & ~flush;
  assign is_div   = (req_op == 3'd3) | (req_op == 3'd4);
  assign div_skip = is_div & (req_rt == 32'd0) & (DIVZ_SKIP != 0);

  // Next-state, operand capture and HI/LO update
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    src0_d  = src0_q;
    src1_d  = src1_q;
    op_d    = op_q;
    sign_d  = sign_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (req_op)
            3'd1, 3'd2, 3'd3, 3'd4: begin
              // a divide by zero may be swallowed here without touching the unit
              if (!div_skip) begin
                src0_d  = req_rs;
                src1_d  = req_rt;
                op_d    = (req_op <= 3'd2) ? OP_MUL : OP_DIV;
                sign_d  = (req_op == 3'd1) | (req_op == 3'd3);
                state_d = S_ISSUE;
              end
            end
            3'd5:    hi_d = req_rs;
            3'd6:    lo_d = req_rs;
            default: ;
          endcase
        end
      end
      S_ISSUE: begin
        // once the unit took the operands a flush can only drop the result
        if (md_in_ready) begin
          state_d = flush ? S_DISCARD : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (md_out_valid) begin
          if (!flush) begin
            hi_d = md_res1;
            lo_d = md_res0;
          end
          state_d = S_IDLE;
        end else if (flush) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (md_out_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) begin
      op_d = OP_NONE;
    end
  end

  // State and architectural register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      src0_q  <= 32'd0;
      src1_q  <= 32'd0;
      op_q    <= OP_NONE;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      src0_q  <= src0_d;
      src1_q  <= src1_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
    end
  end

`ifdef MD_FORWARD_EN
  assign fwd = (state_q == S_WAIT) & md_out_valid & ~flush;
`else
  assign fwd = 1'b0;
`endif

  assign hazard_req   = req_valid & (req_op >= 3'd1) & (req_op <= 3'd6);
  assign req_ready    = (state_q == S_IDLE);
  assign stall        = (state_q != S_IDLE) & ((rd_en & ~fwd) | hazard_req);
  assign rd_data      = fwd ? (rd_sel ? md_res1 : md_res0) : (rd_sel ? hi_q : lo_q);
  assign md_src0      = src0_q;
  assign md_src1      = src1_q;
  assign md_op        = op_q;
  assign md_sign      = sign_q;
  assign md_in_valid  = (state_q == S_ISSUE);
  assign md_out_ready = (state_q == S_WAIT) | (state_q == S_DISCARD);

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - randomized bench for md_issue_ctrl against a transaction-level HI/LO model
module tb_md_issue_ctrl;

`ifdef MD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int N_CYC = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_rs;
  logic [31:0] req_rt;
  logic        req_ready;
  logic        flush;
  logic        rd_en;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        stall;
  logic [31:0] md_src0;
  logic [31:0] md_src1;
  logic [1:0]  md_op;
  logic        md_sign;
  logic        md_in_valid;
  logic        md_in_ready;
  logic        md_out_valid;
  logic        md_out_ready;
  logic [31:0] md_res0;
  logic [31:0] md_res1;

  always #5 clk = ~clk;

  md_issue_ctrl #(.DIVZ_SKIP(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_rs       (req_rs),
    .req_rt       (req_rt),
    .req_ready    (req_ready),
    .flush        (flush),
    .rd_en        (rd_en),
    .rd_sel       (rd_sel),
    .rd_data      (rd_data),
    .stall        (stall),
    .md_src0      (md_src0),
    .md_src1      (md_src1),
    .md_op        (md_op),
    .md_sign      (md_sign),
    .md_in_valid  (md_in_valid),
    .md_in_ready  (md_in_ready),
    .md_out_valid (md_out_valid),
    .md_out_ready (md_out_ready),
    .md_res0      (md_res0),
    .md_res1      (md_res1)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // kind: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU; returns {HI, LO}
  function automatic logic [63:0] md_calc(input int kind, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    int qa, qb, q, r;
    case (kind)
      1: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      2: begin
        ua = {32'd0, a};
        ub = {32'd0, b};
        return 64'(ua * ub);
      end
      3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (b == 32'hFFFF_FFFF) return {32'd0, 32'd0 - a};
        qa = a;
        qb = b;
        q = qa / qb;
        r = qa % qb;
        return {32'(r), 32'(q)};
      end
      4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom % 10);
      3: return 32'hFFFF_FFF9;
      default: return 32'($urandom);
    endcase
  endfunction

  // reference model: architectural HI/LO plus the one outstanding operation
  logic [31:0] m_hi, m_lo;
  bit          m_busy, m_issued, m_keep;
  int          p_kind;
  logic [31:0] p_rs, p_rt;
  logic [63:0] p_res;

  // bench-side multiply/divide unit
  bit          u_busy;
  int          u_cnt;
  logic [63:0] u_res;
  int          u_kind;

  bit          exp_fwd, exp_stall, hazard;
  logic [31:0] exp_rd;

  initial begin
    m_hi = 0; m_lo = 0; m_busy = 0; m_issued = 0; m_keep = 0;
    p_kind = 0; p_rs = 0; p_rt = 0; p_res = 0;
    u_busy = 0; u_cnt = 0; u_res = 0; u_kind = 0;
    reset = 1'b1; req_valid = 0; req_op = 0; req_rs = 0; req_rt = 0;
    flush = 0; rd_en = 0; rd_sel = 0; md_in_ready = 0; md_out_valid = 0;
    md_res0 = 0; md_res1 = 0;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      if (cyc >= 2) begin
        reset     = ($urandom % 300) == 0;
        req_valid = ($urandom % 10) < 6;
        req_op    = 3'($urandom % 8);
        req_rs    = pick();
        req_rt    = pick();
        flush     = ($urandom % 12) == 0;
        rd_en     = $urandom % 2;
        rd_sel    = $urandom % 2;
      end
      md_in_ready  = !u_busy && (($urandom % 4) != 0);
      md_out_valid = u_busy && (u_cnt == 0);
      md_res0      = u_res[31:0];
      md_res1      = u_res[63:32];

      @(negedge clk);

      exp_fwd   = FWD && m_busy && m_issued && m_keep && md_out_valid && !flush;
      hazard    = req_valid && (req_op >= 3'd1) && (req_op <= 3'd6);
      exp_stall = m_busy && ((rd_en && !exp_fwd) || hazard);
      exp_rd    = exp_fwd ? (rd_sel ? p_res[63:32] : p_res[31:0]) : (rd_sel ? m_hi : m_lo);

      check("req_ready", 32'(req_ready), 32'(!m_busy));
      check("stall", 32'(stall), 32'(exp_stall));
      check("rd_data", rd_data, exp_rd);
      check("md_in_valid", 32'(md_in_valid), 32'(m_busy && !m_issued));
      check("md_out_ready", 32'(md_out_ready), 32'(m_busy && m_issued));
      if (!m_busy) check("md_op_idle", 32'(md_op), 32'd0);
      if (m_busy && !m_issued) begin
        check("md_op", 32'(md_op), (p_kind <= 2) ? 32'd1 : 32'd2);
        check("md_sign", 32'(md_sign), 32'((p_kind == 1) || (p_kind == 3)));
        check("md_src0", md_src0, p_rs);
        check("md_src1", md_src1, p_rt);
      end

      // advance the reference model across this edge
      if (reset) begin
        m_busy = 0; m_hi = 0; m_lo = 0;
      end else if (!m_busy) begin
        if (req_valid && !flush) begin
          if (req_op == 3'd5) m_hi = req_rs;
          else if (req_op == 3'd6) m_lo = req_rs;
          else if (req_op >= 3'd1 && req_op <= 3'd4) begin
            if (!((req_op >= 3'd3) && (req_rt == 32'd0))) begin
              m_busy = 1; m_issued = 0; m_keep = 1;
              p_kind = int'(req_op); p_rs = req_rs; p_rt = req_rt;
              p_res  = md_calc(p_kind, req_rs, req_rt);
            end
          end
        end
      end else if (!m_issued) begin
        if (md_in_ready) begin
          m_issued = 1; m_keep = !flush;
        end else if (flush) begin
          m_busy = 0;
        end
      end else if (m_keep) begin
        if (md_out_valid) begin
          if (!flush) begin
            m_hi = p_res[63:32];
            m_lo = p_res[31:0];
          end
          m_busy = 0;
        end else if (flush) begin
          m_keep = 0;
        end
      end else if (md_out_valid) begin
        m_busy = 0;
      end

      // advance the unit: multiply answers the cycle after the handshake
      if (reset) begin
        u_busy = 0;
      end else begin
        if (u_busy && u_cnt == 0 && md_out_ready) u_busy = 0;
        else if (u_busy && u_cnt > 0) u_cnt--;
        if (md_in_valid && md_in_ready) begin
          if (md_op == 2'b01) u_kind = md_sign ? 1 : 2;
          else if (md_op == 2'b10) u_kind = md_sign ? 3 : 4;
          else u_kind = 0;
          u_res  = md_calc(u_kind, md_src0, md_src1);
          u_busy = 1;
          u_cnt  = (md_op == 2'b01) ? 0 : int'($urandom % 6);
        end
      end

      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Initiator side of the multiply/divide valid/ready interface.
- Accepts decoded HI/LO-class instructions from the execute stage: MULT, MULTU, DIV, DIVU, MTHI, MTLO, and HI/LO reads.
- Issues operands to MulDivUnit and collects its result into architectural HI/LO registers.
- Generates the pipeline stall for HI/LO hazards and supports flush (exception) cancellation.

Parameters:
- DIVZ_SKIP, 1, 1: DIV/DIVU with rt==0 is not issued and leaves HI/LO unchanged; 0: issued to the unit like any other divide.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  instruction request valid
- req_op  in  3  instruction kind: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 treated as NOP
- req_rs  in  32  rs operand (src0); write data for MTHI/MTLO
- req_rt  in  32  rt operand (src1)
- req_ready  out  1  request accepted this cycle when high
- flush  in  1  cancel the current/in-flight operation
- rd_en  in  1  execute stage reads HI/LO (MFHI/MFLO)
- rd_sel  in  1  0 = LO, 1 = HI
- rd_data  out  32  selected HI/LO value
- stall  out  1  pipeline must hold
- md_src0  out  32  unit operand 0
- md_src1  out  32  unit operand 1
- md_op  out  2  unit op: 2'b00 none, 2'b01 MUL, 2'b10 DIV
- md_sign  out  1  signed operation
- md_in_valid  out  1  request to unit
- md_in_ready  in  1  unit can accept
- md_out_valid  in  1  unit result valid
- md_out_ready  out  1  controller accepts result
- md_res0  in  32  LO result (product low / quotient)
- md_res1  in  32  HI result (product high / remainder)

Behaviour:
- Reset: HI=LO=0; state IDLE; md_src0/md_src1/md_op/md_sign/md_in_valid/md_out_ready = 0; req_ready=1; stall=0.
- Reset mid-operation returns to IDLE with no HI/LO write; the unit shares the same reset.
- States: IDLE, ISSUE, WAIT, DISCARD.
- req_ready = (state==IDLE). A request is accepted on an edge with req_valid & req_ready & !flush.
- IDLE, MTHI/MTLO accepted: HI/LO <= req_rs at that edge; stay IDLE.
- IDLE, NOP accepted: no effect.
- IDLE, MULT/MULTU/DIV/DIVU accepted: register req_rs→md_src0, req_rt→md_src1, md_op, md_sign (1 for MULT/DIV); go to ISSUE.
  - Exception: DIV/DIVU with req_rt==0 and DIVZ_SKIP=1 is consumed with no issue and stays IDLE.
- ISSUE: md_in_valid=1; operands and op stay stable.
  - On md_in_ready (handshake): WAIT, or DISCARD if flush is high on the same edge.
  - No handshake and flush: IDLE, md_in_valid drops.
- WAIT: md_out_ready=1. On md_out_valid:
  - no flush: HI<=md_res1, LO<=md_res0, go IDLE;
  - flush: result dropped, go IDLE.
  - Flush without md_out_valid: go DISCARD.
- DISCARD: md_out_ready=1; on md_out_valid go IDLE with HI/LO unchanged; flush ignored.
- md_op returns to 2'b00 on entering IDLE.
- Latency:
  - MULT: accept edge E, unit handshake E+1, HI/LO written E+2.
  - DIV: E+1 plus the unit's divide time.
- stall = (state!=IDLE) & (rd_en | (req_valid & req_op in 1..6)).
- rd_data = rd_sel ? HI : LO. It is combinational from the registers, and valid whenever stall=0.
- Simultaneous accepted MTHI/MTLO and rd_en in IDLE: rd_data shows the old value; the write lands at the edge.

Optional Feature:
- MD_FORWARD_EN defined: in WAIT with md_out_valid & !flush, rd_data = rd_sel ? md_res1 : md_res0, and stall is deasserted for rd_en that cycle.
- MD_FORWARD_EN undefined: the reader stalls until state is IDLE and reads the registers the next cycle.

Test Plan:
- MULT rs=0xFFFFFFFD, rt=5 → after 2 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1; stall high on MFLO during WAIT, then 0.
- MULTU rs=0xFFFFFFFF, rt=2 → HI=0x00000001, LO=0xFFFFFFFE; md_sign=0, md_op=2'b01 during ISSUE.
- DIV rs=0xFFFFFFF9, rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=100, rt=7 → LO=14, HI=2.
- DIV issued, then flush during WAIT → DISCARD; after md_out_valid, HI/LO keep their prior values; a following MTLO 0x1234 is accepted once IDLE gives LO=0x1234.
- MTHI 0xABCD accepted while a DIV is in WAIT → req_ready=0, stall=1, HI unchanged until IDLE, then the accepted MTHI gives HI=0xABCD.
- DIVU rt=0 with DIVZ_SKIP=1 → md_in_valid never asserts, HI/LO unchanged; reset asserted in WAIT → state IDLE, HI=LO=0.
